// File: rtl/hive_stk_lifo_if.sv
// Operand-stack port bundle: request side (clear/push/pop) and stack status.
interface hive_stk_lifo_if #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 5
);
    logic               clr_i;
    logic               pop_i;
    logic               push_i;
    logic [DATA_W-1:0]  push_data_i;
    logic [DATA_W-1:0]  data_o;
    logic [DEPTH_W:0]   level_o;
    logic               empty_o;
    logic               full_o;
    logic               pop_er_o;
    logic               push_er_o;

    modport master (
        output clr_i, pop_i, push_i, push_data_i,
        input  data_o, level_o, empty_o, full_o, pop_er_o, push_er_o
    );

    modport slave (
        input  clr_i, pop_i, push_i, push_data_i,
        output data_o, level_o, empty_o, full_o, pop_er_o, push_er_o
    );
endinterface

// File: rtl/hive_stk_lifo.sv
// ALU data stack: top-of-stack lives in a register so the ALU can consume it
// in the same cycle it pops; the rest of the stack sits in an array indexed
// by level. One operation per cycle, error pulses on under/overflow.
module hive_stk_lifo #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 5
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    hive_stk_lifo_if.slave bus
);
    localparam int                 ENTRIES = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0]   LVL_ONE = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W:0]   LVL_CAP = (DEPTH_W+1)'(ENTRIES);
    localparam logic [DEPTH_W-1:0] IDX_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] IDX_TWO = DEPTH_W'(2);

    logic [DATA_W-1:0]  top_q, top_d;
    logic [DEPTH_W:0]   level_q, level_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               pop_er_q, pop_er_d;
    logic               push_er_q, push_er_d;

    logic [DATA_W-1:0]  mem [ENTRIES];
    logic               wr_en;
    logic [DEPTH_W-1:0] wr_idx;
    logic [DEPTH_W-1:0] rd_idx;

    // Index arithmetic is done modulo 2^DEPTH_W: the spill slot (level-1)
    // is only used when not full, and the refill slot (level-2) is only used
    // for level >= 2, where the low bits wrap to the right entry even at full.
    assign wr_idx = level_q[DEPTH_W-1:0] - IDX_ONE;
    assign rd_idx = level_q[DEPTH_W-1:0] - IDX_TWO;

    // Next-state selection in priority order: clear, replace, push, pop.
    always_comb begin
        top_d     = top_q;
        level_d   = level_q;
        pop_er_d  = 1'b0;
        push_er_d = 1'b0;
        wr_en     = 1'b0;
        if (bus.clr_i) begin
            top_d   = '0;
            level_d = '0;
        end else if (bus.push_i && bus.pop_i) begin
            // Replace the top; at empty the pop faults but the push still lands.
            top_d = bus.push_data_i;
            if (level_q == '0) begin
                pop_er_d = 1'b1;
                level_d  = LVL_ONE;
            end
        end else if (bus.push_i) begin
            if (full_q) begin
                push_er_d = 1'b1;
            end else begin
                top_d   = bus.push_data_i;
                level_d = level_q + LVL_ONE;
                wr_en   = (level_q != '0);
            end
        end else if (bus.pop_i) begin
            if (level_q == '0) begin
                pop_er_d = 1'b1;
            end else if (level_q == LVL_ONE) begin
                top_d   = '0;
                level_d = '0;
            end else begin
                top_d   = mem[rd_idx];
                level_d = level_q - LVL_ONE;
            end
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_CAP);
    end

    // Control/status registers; flags come from the next level so they
    // always agree with level_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            top_q     <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            pop_er_q  <= 1'b0;
            push_er_q <= 1'b0;
        end else begin
            top_q     <= top_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            pop_er_q  <= pop_er_d;
            push_er_q <= push_er_d;
        end
    end

    // Spill storage: old top is written below the new one; no reset needed
    // since only entries under the current level are ever read.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_idx] <= top_q;
    end

    assign bus.data_o    = top_q;
    assign bus.level_o   = level_q;
    assign bus.empty_o   = empty_q;
    assign bus.full_o    = full_q;
    assign bus.pop_er_o  = pop_er_q;
    assign bus.push_er_o = push_er_q;
endmodule

// File: tb/tb_hive_stk_lifo.sv
// Bench for hive_stk_lifo: directed vector table, hand-written corner
// sequences (fill/overflow, async reset) and a queue-model random stream.
module tb_hive_stk_lifo;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CAP = 1 << AW;

    logic clk;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    hive_stk_lifo_if #(.DATA_W(DW), .DEPTH_W(AW)) bus ();

    hive_stk_lifo #(.DATA_W(DW), .DEPTH_W(AW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        bit          push;
        bit          pop;
        logic [31:0] d;
        logic [31:0] ed;
        int          el;
        bit          ee;
        bit          ef;
        bit          epe;
        bit          epu;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] ed, input int el,
                       input bit ee, input bit ef, input bit epe, input bit epu);
        n_total++;
        if (bus.data_o !== ed || int'(bus.level_o) != el || bus.empty_o !== ee ||
            bus.full_o !== ef || bus.pop_er_o !== epe || bus.push_er_o !== epu) begin
            $display("FAIL %s: got data=%h lvl=%0d e=%b f=%b pe=%b pu=%b, want data=%h lvl=%0d e=%b f=%b pe=%b pu=%b",
                     nm, bus.data_o, bus.level_o, bus.empty_o, bus.full_o, bus.pop_er_o, bus.push_er_o,
                     ed, el, ee, ef, epe, epu);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of request at the falling edge, sample after the rise.
    task automatic op(input bit c, input bit pu, input bit po, input logic [31:0] d);
        @(negedge clk);
        bus.clr_i = c; bus.push_i = pu; bus.pop_i = po; bus.push_data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] ed;
        bit          epe, epu, c, pu, po;
        logic [31:0] d;
        int          push_pct;

        //                clr push pop  data        exp_data    lvl e f pe pu
        vecs[0]  = '{1'b0,1'b1,1'b0,32'h11,      32'h11,      1, 0,0,0,0};
        vecs[1]  = '{1'b0,1'b1,1'b0,32'h22,      32'h22,      2, 0,0,0,0};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h33,      32'h33,      3, 0,0,0,0};
        vecs[3]  = '{1'b0,1'b0,1'b1,32'h0,       32'h22,      2, 0,0,0,0};
        vecs[4]  = '{1'b0,1'b0,1'b1,32'h0,       32'h11,      1, 0,0,0,0};
        vecs[5]  = '{1'b0,1'b0,1'b1,32'h0,       32'h0,       0, 1,0,0,0};
        vecs[6]  = '{1'b0,1'b0,1'b1,32'h0,       32'h0,       0, 1,0,1,0};
        vecs[7]  = '{1'b0,1'b0,1'b0,32'h0,       32'h0,       0, 1,0,0,0};
        vecs[8]  = '{1'b0,1'b1,1'b1,32'h5,       32'h5,       1, 0,0,1,0};
        vecs[9]  = '{1'b0,1'b1,1'b0,32'h6,       32'h6,       2, 0,0,0,0};
        vecs[10] = '{1'b0,1'b1,1'b0,32'h7,       32'h7,       3, 0,0,0,0};
        vecs[11] = '{1'b0,1'b1,1'b0,32'h8,       32'h8,       4, 0,0,0,0};
        vecs[12] = '{1'b1,1'b1,1'b0,32'h9,       32'h0,       0, 1,0,0,0};
        vecs[13] = '{1'b0,1'b0,1'b1,32'h0,       32'h0,       0, 1,0,1,0};
        vecs[14] = '{1'b0,1'b0,1'b1,32'h0,       32'h0,       0, 1,0,1,0};
        vecs[15] = '{1'b0,1'b1,1'b1,32'hA,       32'hA,       1, 0,0,1,0};

        bus.clr_i = 1'b0; bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.push_data_i = '0;
        rst_n = 1'b0;
        #12;
        chk("reset", 32'h0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            op(vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].d);
            chk($sformatf("vec%0d", i), vecs[i].ed, vecs[i].el, vecs[i].ee, vecs[i].ef,
                vecs[i].epe, vecs[i].epu);
        end

        // Fill to capacity, overflow, replace at full, then refill from array.
        op(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < CAP; i++) op(1'b0, 1'b1, 1'b0, 32'(i));
        chk("fill", 32'd31, 32, 0, 1, 0, 0);
        op(1'b0, 1'b1, 1'b0, 32'hDEAD);
        chk("overflow", 32'd31, 32, 0, 1, 0, 1);
        op(1'b0, 1'b0, 1'b0, 32'h0);
        chk("overflow_pulse_end", 32'd31, 32, 0, 1, 0, 0);
        op(1'b0, 1'b1, 1'b1, 32'hBEEF);
        chk("replace_full", 32'hBEEF, 32, 0, 1, 0, 0);
        op(1'b0, 1'b0, 1'b1, 32'h0);
        chk("pop_from_full", 32'd30, 31, 0, 0, 0, 0);
        op(1'b0, 1'b0, 1'b1, 32'h0);
        chk("pop_again", 32'd29, 30, 0, 0, 0, 0);

        // Async reset mid-cycle with level 7 and a push in flight.
        op(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) op(1'b0, 1'b1, 1'b0, 32'h70 + 32'(i));
        chk("level7", 32'h76, 7, 0, 0, 0, 0);
        @(negedge clk);
        bus.push_i = 1'b1; bus.push_data_i = 32'h77;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'h0, 0, 1, 0, 0, 0);
        bus.push_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_release_idle", 32'h0, 0, 1, 0, 0, 0);
        op(1'b0, 1'b1, 1'b0, 32'hA);
        chk("push_after_reset", 32'hA, 1, 0, 0, 0, 0);

        // Random stream against a reference queue.
        op(1'b1, 1'b0, 1'b0, 32'h0);
        q.delete();
        push_pct = 50;
        for (int n = 0; n < 10000; n++) begin
            if (n % 500 == 0) push_pct = (n / 500) % 2 ? 30 : 75;
            c  = ($urandom_range(0, 63) == 0);
            pu = ($urandom_range(0, 99) < push_pct);
            po = ($urandom_range(0, 99) < 100 - push_pct);
            d  = $urandom;
            epe = 1'b0; epu = 1'b0;
            if (c) q.delete();
            else if (pu && po) begin
                if (q.size() == 0) begin epe = 1'b1; q.push_back(d); end
                else q[q.size()-1] = d;
            end else if (pu) begin
                if (q.size() == CAP) epu = 1'b1;
                else q.push_back(d);
            end else if (po) begin
                if (q.size() == 0) epe = 1'b1;
                else void'(q.pop_back());
            end
            ed = (q.size() == 0) ? 32'h0 : q[q.size()-1];
            op(c, pu, po, d);
            chk($sformatf("rand%0d", n), ed, q.size(), q.size() == 0, q.size() == CAP, epe, epu);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
